// File: rtl/pipe_ctrl_if.sv
// Pipeline hazard-control bundle: stall/event requests in, per-register stall/flush and
// redirect controls out.
interface pipe_ctrl_if;
    logic       stall0;
    logic       stall1;
    logic       stall2;
    logic       stall3;
    logic       exc_valid;
    logic       eret;
    logic       irq;
    logic       PC_Stall;
    logic       IF_ID_Stall;
    logic       IF_ID_Flush;
    logic       ID_EX_Stall;
    logic       ID_EX_Flush;
    logic       EX_MEM_Stall;
    logic       EX_MEM_Flush;
    logic       MEM_WB_Stall;
    logic       MEM_WB_Flush;
    logic       redirect_valid;
    logic [1:0] flush_cause;
    logic       irq_ack;

    // Pipeline side: raises requests, consumes the controls.
    modport master (
        output stall0, stall1, stall2, stall3, exc_valid, eret, irq,
        input  PC_Stall, IF_ID_Stall, IF_ID_Flush, ID_EX_Stall, ID_EX_Flush,
               EX_MEM_Stall, EX_MEM_Flush, MEM_WB_Stall, MEM_WB_Flush,
               redirect_valid, flush_cause, irq_ack
    );

    // Controller side.
    modport slave (
        input  stall0, stall1, stall2, stall3, exc_valid, eret, irq,
        output PC_Stall, IF_ID_Stall, IF_ID_Flush, ID_EX_Stall, ID_EX_Flush,
               EX_MEM_Stall, EX_MEM_Flush, MEM_WB_Stall, MEM_WB_Flush,
               redirect_valid, flush_cause, irq_ack
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline hazard controller: priority stall/flush generation plus an
// exception/ERET/interrupt flush sequencer (RUN -> WAIT while MEM is busy -> DRAIN).
module pipe_ctrl (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);
    typedef enum logic [1:0] {StRun, StWait, StDrain} state_e;

    // Cause codes double as priority ranks: lower nonzero value wins.
    localparam logic [1:0] CauseNone = 2'b00;
    localparam logic [1:0] CauseExc  = 2'b01;
    localparam logic [1:0] CauseEret = 2'b10;
    localparam logic [1:0] CauseIrq  = 2'b11;

    state_e     state_q, state_d;
    logic       irq_pend_q, irq_pend_d;
    logic [1:0] cause_q, cause_d;
    logic [1:0] drain_cnt_q, drain_cnt_d;
    logic [1:0] cur_cause;
    logic [1:0] eff_cause;
    logic       take;

    // Decode this cycle's event cause and decide whether the flush is taken now.
    always_comb begin
        cur_cause = CauseNone;
        if (bus.exc_valid) begin
            cur_cause = CauseExc;
        end else if (bus.eret) begin
            cur_cause = CauseEret;
        end else if (irq_pend_q && state_q != StDrain) begin
            cur_cause = CauseIrq;
        end
        // While waiting, the latched cause only ever upgrades.
        eff_cause = cur_cause;
        if (state_q == StWait && (cur_cause == CauseNone || cur_cause > cause_q)) begin
            eff_cause = cause_q;
        end
        take = !bus.stall3 && (eff_cause != CauseNone);
    end

    // State and bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StRun;
            irq_pend_q  <= 1'b0;
            cause_q     <= CauseNone;
            drain_cnt_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            irq_pend_q  <= irq_pend_d;
            cause_q     <= cause_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        drain_cnt_d = drain_cnt_q;
        irq_pend_d  = irq_pend_q;
        if (bus.irq && state_q != StDrain) begin
            irq_pend_d = 1'b1;
        end
        // Taking the interrupt consumes the pending request.
        if (take && eff_cause == CauseIrq) begin
            irq_pend_d = 1'b0;
        end
        unique case (state_q)
            StRun, StDrain: begin
                if (take) begin
                    state_d     = StDrain;
                    drain_cnt_d = 2'd2;
                    cause_d     = CauseNone;
                end else if (eff_cause != CauseNone) begin
                    state_d     = StWait;
                    cause_d     = eff_cause;
                    drain_cnt_d = 2'd0;
                end else if (state_q == StDrain) begin
                    drain_cnt_d = drain_cnt_q - 2'd1;
                    if (drain_cnt_q <= 2'd1) begin
                        state_d     = StRun;
                        drain_cnt_d = 2'd0;
                    end
                end
            end
            StWait: begin
                if (take) begin
                    state_d     = StDrain;
                    drain_cnt_d = 2'd2;
                    cause_d     = CauseNone;
                end else begin
                    cause_d = eff_cause;
                end
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    // Outputs: full flush on a taken event, else stall everything up to the highest
    // stalling stage and flush the register just after it. Held low during reset.
    always_comb begin
        bus.PC_Stall       = 1'b0;
        bus.IF_ID_Stall    = 1'b0;
        bus.IF_ID_Flush    = 1'b0;
        bus.ID_EX_Stall    = 1'b0;
        bus.ID_EX_Flush    = 1'b0;
        bus.EX_MEM_Stall   = 1'b0;
        bus.EX_MEM_Flush   = 1'b0;
        bus.MEM_WB_Stall   = 1'b0;
        bus.MEM_WB_Flush   = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.flush_cause    = CauseNone;
        bus.irq_ack        = 1'b0;
        if (!rst) begin
            if (take) begin
                bus.IF_ID_Flush    = 1'b1;
                bus.ID_EX_Flush    = 1'b1;
                bus.EX_MEM_Flush   = 1'b1;
                bus.MEM_WB_Flush   = 1'b1;
                bus.redirect_valid = 1'b1;
                bus.flush_cause    = eff_cause;
                bus.irq_ack        = (eff_cause == CauseIrq);
            end else if (bus.stall3) begin
                bus.PC_Stall     = 1'b1;
                bus.IF_ID_Stall  = 1'b1;
                bus.ID_EX_Stall  = 1'b1;
                bus.EX_MEM_Stall = 1'b1;
                bus.MEM_WB_Flush = 1'b1;
            end else if (bus.stall2) begin
                bus.PC_Stall     = 1'b1;
                bus.IF_ID_Stall  = 1'b1;
                bus.ID_EX_Stall  = 1'b1;
                bus.EX_MEM_Flush = 1'b1;
            end else if (bus.stall1) begin
                bus.PC_Stall    = 1'b1;
                bus.IF_ID_Stall = 1'b1;
                bus.ID_EX_Flush = 1'b1;
            end else if (bus.stall0) begin
                bus.PC_Stall    = 1'b1;
                bus.IF_ID_Flush = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: stall-rule vector table, directed flush sequences,
// then randomized traffic against a behavioural reference model.
module tb_pipe_ctrl;
    logic clk;
    logic rst;
    pipe_ctrl_if bus ();

    pipe_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs packed as {PC_S, IFID_S, IFID_F, IDEX_S, IDEX_F, EXMEM_S, EXMEM_F,
    // MEMWB_S, MEMWB_F, redirect, cause[1:0], ack}.
    logic [12:0] obs;
    assign obs = {bus.PC_Stall, bus.IF_ID_Stall, bus.IF_ID_Flush, bus.ID_EX_Stall,
                  bus.ID_EX_Flush, bus.EX_MEM_Stall, bus.EX_MEM_Flush, bus.MEM_WB_Stall,
                  bus.MEM_WB_Flush, bus.redirect_valid, bus.flush_cause, bus.irq_ack};

    localparam logic [12:0] Idle       = 13'b0000000000000;
    localparam logic [12:0] FlushExc   = 13'b0010101011010;
    localparam logic [12:0] FlushEret  = 13'b0010101011100;
    localparam logic [12:0] FlushIrq   = 13'b0010101011111;
    localparam logic [12:0] Stall3Rule = 13'b1101010010000;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  stall;
        logic [12:0] exp;
    } vec_t;

    vec_t vecs[10];

    // Reference model state: pending irq, cause waiting on MEM (0 = none, else rank 1..3),
    // drain cycles still to run.
    int m_pend  = 0;
    int m_wait  = 0;
    int m_drain = 0;

    task automatic drive(input logic [3:0] s, input logic e, input logic r, input logic i);
        bus.stall0    = s[0];
        bus.stall1    = s[1];
        bus.stall2    = s[2];
        bus.stall3    = s[3];
        bus.exc_valid = e;
        bus.eret      = r;
        bus.irq       = i;
    endtask

    task automatic check(input string name, input logic [12:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string name, input logic [3:0] s, input logic e, input logic r,
                        input logic i, input logic [12:0] exp);
        drive(s, e, r, i);
        #1;
        check(name, exp);
        tick();
    endtask

    // Expected outputs for this cycle, then advance the model across the coming edge.
    task automatic model_step(input logic rs, input logic [3:0] s, input logic e,
                              input logic r, input logic i, output logic [12:0] exp);
        logic [4:0] stv;
        logic [4:0] flv;
        logic       rd;
        logic [1:0] c;
        logic       ack;
        int         best;
        int         k;
        bit         draining;
        bit         take;
        exp = '0;
        if (rs) begin
            m_pend  = 0;
            m_wait  = 0;
            m_drain = 0;
            return;
        end
        stv = '0;
        flv = '0;
        rd  = 1'b0;
        c   = 2'b00;
        ack = 1'b0;
        draining = (m_drain > 0);
        best = 4;
        if (m_wait != 0) best = m_wait;
        if (m_pend != 0 && !draining && best > 3) best = 3;
        if (r && best > 2) best = 2;
        if (e) best = 1;
        take = (best != 4) && !s[3];
        if (take) begin
            flv = 5'b11110;
            rd  = 1'b1;
            c   = 2'(best);
            ack = (best == 3);
        end else begin
            k = -1;
            for (int j = 0; j < 4; j++) if (s[j]) k = j;
            for (int j = 0; j <= k; j++) stv[j] = 1'b1;
            if (k >= 0) flv[k + 1] = 1'b1;
        end
        exp = {stv[0], stv[1], flv[1], stv[2], flv[2], stv[3], flv[3], stv[4], flv[4],
               rd, c, ack};
        if (take && best == 3) m_pend = 0;
        else if (i && !draining) m_pend = 1;
        if (take) begin
            m_wait  = 0;
            m_drain = 2;
        end else if (best != 4) begin
            m_wait  = best;
            m_drain = 0;
        end else if (draining) begin
            m_drain--;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected end before 1000000");
        $fatal(1, "timeout");
    end

    initial begin
        logic [12:0] exp;
        logic [3:0]  s;
        logic        rs;
        vecs[0] = '{4'b0000, Idle};
        vecs[1] = '{4'b0001, 13'b1010000000000};
        vecs[2] = '{4'b0010, 13'b1100100000000};
        vecs[3] = '{4'b0100, 13'b1101001000000};
        vecs[4] = '{4'b1000, Stall3Rule};
        vecs[5] = '{4'b0101, 13'b1101001000000};
        vecs[6] = '{4'b0011, 13'b1100100000000};
        vecs[7] = '{4'b1111, Stall3Rule};
        vecs[8] = '{4'b0110, 13'b1101001000000};
        vecs[9] = '{4'b1010, Stall3Rule};

        // Reset holds every output low whatever the inputs.
        rst = 1'b1;
        drive(4'b1111, 1'b1, 1'b1, 1'b1);
        #2;
        check("reset_all_inputs", Idle);
        tick();
        drive(4'b0010, 1'b0, 1'b0, 1'b0);
        #1;
        check("reset_stall1", Idle);
        tick();

        // Event accepted in the first cycle out of reset, then two drain cycles.
        rst = 1'b0;
        step("first_event", 4'b0000, 1'b1, 1'b0, 1'b0, FlushExc);
        step("drain_a", 4'b0000, 1'b0, 1'b0, 1'b0, Idle);
        step("drain_b", 4'b0000, 1'b0, 1'b0, 1'b0, Idle);

        for (int n = 0; n < 10; n++) begin
            step($sformatf("stall_vec%0d", n), vecs[n].stall, 1'b0, 1'b0, 1'b0, vecs[n].exp);
        end

        // Exception held off by MEM busy, then flush, drain, irq latency and drain masking.
        step("wait_1", 4'b1000, 1'b1, 1'b0, 1'b0, Stall3Rule);
        step("wait_2", 4'b1000, 1'b1, 1'b0, 1'b0, Stall3Rule);
        step("wait_3", 4'b1000, 1'b1, 1'b0, 1'b0, Stall3Rule);
        step("wait_flush", 4'b0000, 1'b0, 1'b0, 1'b0, FlushExc);
        step("wait_drain_a", 4'b0000, 1'b0, 1'b0, 1'b0, Idle);
        step("wait_drain_b", 4'b0000, 1'b0, 1'b0, 1'b0, Idle);
        step("irq_pulse", 4'b0000, 1'b0, 1'b0, 1'b1, Idle);
        step("irq_taken", 4'b0000, 1'b0, 1'b0, 1'b0, FlushIrq);
        step("irq_in_drain", 4'b0000, 1'b0, 1'b0, 1'b1, Idle);
        step("irq_drain_b", 4'b0000, 1'b0, 1'b0, 1'b0, Idle);
        step("no_latch_a", 4'b0000, 1'b0, 1'b0, 1'b0, Idle);
        step("no_latch_b", 4'b0000, 1'b0, 1'b0, 1'b0, Idle);

        // Waiting irq upgraded to ERET; the irq stays pending and follows after drain.
        step("up_irq", 4'b0000, 1'b0, 1'b0, 1'b1, Idle);
        step("up_wait_irq", 4'b1000, 1'b0, 1'b0, 1'b0, Stall3Rule);
        step("up_wait_eret", 4'b1000, 1'b0, 1'b1, 1'b0, Stall3Rule);
        step("up_flush_eret", 4'b0000, 1'b0, 1'b0, 1'b0, FlushEret);
        step("up_drain_a", 4'b0000, 1'b0, 1'b0, 1'b0, Idle);
        step("up_drain_b", 4'b0000, 1'b0, 1'b0, 1'b0, Idle);
        step("up_flush_irq", 4'b0000, 1'b0, 1'b0, 1'b0, FlushIrq);
        step("up_drain_c", 4'b0000, 1'b0, 1'b0, 1'b0, Idle);
        step("up_drain_d", 4'b0000, 1'b0, 1'b0, 1'b0, Idle);

        // irq together with exc: exc first, irq right after drain.
        step("both_exc", 4'b0000, 1'b1, 1'b0, 1'b1, FlushExc);
        step("both_drain_a", 4'b0000, 1'b0, 1'b0, 1'b0, Idle);
        step("both_drain_b", 4'b0000, 1'b0, 1'b0, 1'b0, Idle);
        step("both_irq", 4'b0000, 1'b0, 1'b0, 1'b0, FlushIrq);
        step("both_drain_c", 4'b0000, 1'b0, 1'b0, 1'b0, Idle);
        step("both_drain_d", 4'b0000, 1'b0, 1'b0, 1'b0, Idle);

        // Reset in WAIT aborts the pending redirect.
        step("rstw_enter", 4'b1000, 1'b0, 1'b1, 1'b0, Stall3Rule);
        drive(4'b1000, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("rstw_outputs", Idle);
        tick();
        rst = 1'b0;
        step("rstw_after_a", 4'b0000, 1'b0, 1'b0, 1'b0, Idle);
        step("rstw_after_b", 4'b0000, 1'b0, 1'b0, 1'b0, Idle);
        step("rstw_after_c", 4'b0000, 1'b0, 1'b0, 1'b0, Idle);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            rs   = (n == 0) || ($urandom_range(0, 39) == 0);
            s[0] = ($urandom_range(0, 9) < 3);
            s[1] = ($urandom_range(0, 9) < 3);
            s[2] = ($urandom_range(0, 9) < 2);
            s[3] = ($urandom_range(0, 9) < 4);
            rst  = rs;
            drive(s, ($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0),
                  ($urandom_range(0, 7) == 0));
            model_step(rs, s, bus.exc_valid, bus.eret, bus.irq, exp);
            #1;
            check($sformatf("random_%0d", n), exp);
            tick();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
